// File: rtl/udp_tx.sv
// UDP transmit framer: latches ports/length on start, emits the 8-byte header and then
// forwards the payload from an upstream source as one contiguous N-bit-per-beat stream.
module udp_tx #(
    parameter int N           = 2,
    parameter int MAX_PAYLOAD = 1472
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [15:0]  src_port_in,
    input  logic [15:0]  dst_port_in,
    input  logic [15:0]  payload_length_in,
    input  logic         axiiv,
    input  logic [N-1:0] axiid,
    output logic         axiir,
    output logic         axiov,
    output logic [N-1:0] axiod,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam int LOG2N     = $clog2(N);
    localparam int HDR_BEATS = 64 / N;
    localparam int MAX_BEATS = (MAX_PAYLOAD + 8) * 8 / N;
    localparam int CNT_W_RAW = $clog2(MAX_BEATS + 1);
    localparam int CNT_W     = (CNT_W_RAW < 8) ? 8 : CNT_W_RAW;

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(HDR_BEATS);
    localparam logic [15:0]      MAX_LEN = 16'(MAX_PAYLOAD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pbeats;
    logic [63:0]      r_hdr;
    logic             r_axiov;
    logic [N-1:0]     r_axiod;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_pbeats_nxt;
    logic [63:0]      w_hdr_nxt;
    logic             w_axiov_nxt;
    logic [N-1:0]     w_axiod_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_error_nxt;
    logic             w_axiir;
    logic             w_len_ok;
    logic [15:0]      w_udp_len;
    logic [63:0]      w_hdr_new;
    logic [CNT_W-1:0] w_pbeats_in;

    assign w_len_ok    = (payload_length_in <= MAX_LEN);
    assign w_udp_len   = payload_length_in + 16'd8;
    assign w_hdr_new   = {src_port_in, dst_port_in, w_udp_len, 16'h0000};
    // Payload beats = bytes * 8 / N; only stored when the length was accepted, so it fits.
    assign w_pbeats_in = CNT_W'(({16'd0, payload_length_in} << 3) >> LOG2N);

    // The first payload transfer overlaps the last header beat, hence ready in HEADER too.
    always_comb begin
        w_axiir = 1'b0;
        case (r_state)
            S_HEADER:  w_axiir = (r_cnt == H_LAST) && (r_pbeats != '0);
            S_PAYLOAD: w_axiir = (r_cnt != r_pbeats);
            default:   w_axiir = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_pbeats_nxt = r_pbeats;
        w_hdr_nxt    = r_hdr;
        w_axiov_nxt  = 1'b0;
        w_axiod_nxt  = '0;
        w_done_nxt   = 1'b0;
        w_error_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_len_ok) begin
                        w_state_nxt  = S_HEADER;
                        w_cnt_nxt    = CNT_W'(1);
                        w_pbeats_nxt = w_pbeats_in;
                        w_axiov_nxt  = 1'b1;
                        w_axiod_nxt  = w_hdr_new[63 -: N];
                        w_hdr_nxt    = w_hdr_new << N;
                    end else begin
                        w_error_nxt = 1'b1;
                    end
                end
            end

            S_HEADER: begin
                if (r_cnt != H_LAST) begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_axiov_nxt = 1'b1;
                    w_axiod_nxt = r_hdr[63 -: N];
                    w_hdr_nxt   = r_hdr << N;
                end else if (r_pbeats == '0) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else if (axiiv) begin
                    w_state_nxt = S_PAYLOAD;
                    w_cnt_nxt   = CNT_W'(1);
                    w_axiov_nxt = 1'b1;
                    w_axiod_nxt = axiid;
                end else begin
                    w_state_nxt  = S_IDLE;
                    w_error_nxt  = 1'b1;
                    w_cnt_nxt    = '0;
                    w_pbeats_nxt = '0;
                    w_hdr_nxt    = '0;
                end
            end

            S_PAYLOAD: begin
                if (!w_axiir) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else if (axiiv) begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_axiov_nxt = 1'b1;
                    w_axiod_nxt = axiid;
                end else begin
                    w_state_nxt  = S_IDLE;
                    w_error_nxt  = 1'b1;
                    w_cnt_nxt    = '0;
                    w_pbeats_nxt = '0;
                    w_hdr_nxt    = '0;
                end
            end

            S_DONE: begin
                w_state_nxt  = S_IDLE;
                w_cnt_nxt    = '0;
                w_pbeats_nxt = '0;
                w_hdr_nxt    = '0;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_HEADER) || (w_state_nxt == S_PAYLOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_pbeats <= '0;
            r_hdr    <= '0;
            r_axiov  <= 1'b0;
            r_axiod  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pbeats <= w_pbeats_nxt;
            r_hdr    <= w_hdr_nxt;
            r_axiov  <= w_axiov_nxt;
            r_axiod  <= w_axiod_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_error  <= w_error_nxt;
        end
    end

    assign axiir = w_axiir;
    assign axiov = r_axiov;
    assign axiod = r_axiod;
    assign busy  = r_busy;
    assign done  = r_done;
    assign error = r_error;

endmodule
